// File: rtl/vga_sync_gen.sv
// Raster timing master: pixel divider, h/v counters, registered sync/blank decodes,
// frame-start pulse and the frame-rate animation toggle.
module vga_sync_gen #(
    parameter int CLK_DIV     = 2,
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int ANIM_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       blank_n,
    output logic       sync_n,
    output logic       vga_clk,
    output logic       pix_en,
    output logic       frame_start,
    output logic       troca
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW       = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, von_q, von_d;
    logic          fs_q, fs_d, troca_q, troca_d;
    logic          line_end, frame_end;

    assign pix_en    = (div_q == DW'(CLK_DIV - 1));
    assign line_end  = (h_q == 10'(H_TOTAL - 1));
    assign frame_end = line_end && (v_q == 10'(V_TOTAL - 1));

    always_comb begin
        div_d   = pix_en ? '0 : div_q + 1'b1;
        h_d     = h_q;
        v_d     = v_q;
        frm_d   = frm_q;
        troca_d = troca_q;
        fs_d    = 1'b0;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        von_d   = von_q;
        if (pix_en) begin
            h_d = line_end ? 10'd0 : h_q + 10'd1;
            if (line_end) v_d = frame_end ? 10'd0 : v_q + 10'd1;
            if (frame_end) begin
                fs_d = 1'b1;
                if (frm_q == FW'(ANIM_FRAMES - 1)) begin
                    frm_d   = '0;
                    troca_d = ~troca_q;
                end else begin
                    frm_d = frm_q + 1'b1;
                end
            end
            // Decode the next-state counters so the registered outputs line up with them.
            hsync_d = !((h_d >= 10'(HS_START)) && (h_d < 10'(HS_END)));
            vsync_d = !((v_d >= 10'(VS_START)) && (v_d < 10'(VS_END)));
            von_d   = (h_d < 10'(H_VISIBLE)) && (v_d < 10'(V_VISIBLE));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            frm_q   <= '0;
            troca_q <= 1'b0;
            fs_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            von_q   <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frm_q   <= frm_d;
            troca_q <= troca_d;
            fs_q    <= fs_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            von_q   <= von_d;
        end
    end

    generate
        if (CLK_DIV == 1) begin : g_vclk_const
            assign vga_clk = 1'b1;
        end else begin : g_vclk_div
            assign vga_clk = (div_q >= DW'(CLK_DIV / 2));
        end
    endgenerate

    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = von_q;
    assign blank_n     = von_q;
    assign sync_n      = 1'b0;
    assign frame_start = fs_q;
    assign troca       = troca_q;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized run/reset sequences on two shrunk-raster instances, checked against an
// arithmetic model that derives every output from the clock count since reset release.
module tb_vga_sync_gen;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] a_h, a_v, b_h, b_v;
    logic a_hs, a_vs, a_vo, a_bn, a_sn, a_vc, a_pe, a_fs, a_tr;
    logic b_hs, b_vs, b_vo, b_bn, b_sn, b_vc, b_pe, b_fs, b_tr;

    vga_sync_gen #(.CLK_DIV(2), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .ANIM_FRAMES(3))
    u_a (.clk(clk), .reset(reset), .h_counter(a_h), .v_counter(a_v), .hsync(a_hs),
         .vsync(a_vs), .video_on(a_vo), .blank_n(a_bn), .sync_n(a_sn), .vga_clk(a_vc),
         .pix_en(a_pe), .frame_start(a_fs), .troca(a_tr));

    vga_sync_gen #(.CLK_DIV(1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .ANIM_FRAMES(1))
    u_b (.clk(clk), .reset(reset), .h_counter(b_h), .v_counter(b_v), .hsync(b_hs),
         .vsync(b_vs), .video_on(b_vo), .blank_n(b_bn), .sync_n(b_sn), .vga_clk(b_vc),
         .pix_en(b_pe), .frame_start(b_fs), .troca(b_tr));

    int checks = 0;
    int errors = 0;
    int k = 0;  // clock edges since reset release

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Expected outputs from pixel count p = k/d: raster position by div/mod, frames elapsed.
    task automatic check_unit(input string p, input int d, input int anim,
                              input logic [9:0] h, input logic [9:0] v,
                              input logic hs, input logic vs, input logic vo,
                              input logic bn, input logic sn, input logic vc,
                              input logic pe, input logic fs, input logic tr);
        int pix, ph, pv, fr;
        logic e_hs, e_vs, e_vo, e_fs;
        pix  = k / d;
        ph   = pix % HT;
        pv   = (pix / HT) % VT;
        fr   = pix / (HT * VT);
        e_hs = !(ph >= HV + HF && ph < HV + HF + HS);
        e_vs = !(pv >= VV + VF && pv < VV + VF + VS);
        e_vo = (pix > 0) && (ph < HV) && (pv < VV);
        e_fs = (k > 0) && (k % d == 0) && (pix % (HT * VT) == 0);
        chk({p, ".h"}, 32'(h), 32'(ph));
        chk({p, ".v"}, 32'(v), 32'(pv));
        chk({p, ".hsync"}, 32'(hs), 32'(e_hs));
        chk({p, ".vsync"}, 32'(vs), 32'(e_vs));
        chk({p, ".video_on"}, 32'(vo), 32'(e_vo));
        chk({p, ".blank_n"}, 32'(bn), 32'(e_vo));
        chk({p, ".sync_n"}, 32'(sn), 32'd0);
        chk({p, ".vga_clk"}, 32'(vc), (d == 1) ? 32'd1 : 32'((k % d) >= d / 2));
        chk({p, ".pix_en"}, 32'(pe), 32'((k % d) == d - 1));
        chk({p, ".frame_start"}, 32'(fs), 32'(e_fs));
        chk({p, ".troca"}, 32'(tr), 32'((fr / anim) % 2));
    endtask

    task automatic check_both();
        check_unit("a", 2, 3, a_h, a_v, a_hs, a_vs, a_vo, a_bn, a_sn, a_vc, a_pe, a_fs, a_tr);
        check_unit("b", 1, 1, b_h, b_v, b_hs, b_vs, b_vo, b_bn, b_sn, b_vc, b_pe, b_fs, b_tr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            k++;
            check_both();
        end
    endtask

    // Assert reset asynchronously mid-cycle, verify immediate effect, hold, then release.
    task automatic pulse_reset();
        @(negedge clk);
        #($urandom_range(1, 3));
        reset = 1'b0;
        k = 0;
        #1 check_both();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_both();
        reset = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        k = 0;
        check_both();
        reset = 1'b1;
        // Long run covers two troca toggles on the divided instance (3 frames each).
        run(2000);
        repeat (6) begin
            pulse_reset();
            run($urandom_range(20, 700));
        end
        pulse_reset();
        run(HT * VT * 2 + 5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
